spi_txmem_loader: RTL

Fills the SPI transmit memory, port A side, from a SysClk-domain byte stream. Bytes are packed into 32-bit words and written one word per write cycle, starting at word 0 for each frame. Writes are locked out while an SPI transaction is active, so the SPI slave interface never reads a half-written frame. The optional power-up fill writes a fixed pattern over the whole memory after reset.

---
 rtl/spi_txmem_loader_if.sv | 23 ++
 rtl/spi_txmem_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_txmem_loader_if.sv
// Byte-stream input and memory port A write bus of the SPI transmit memory loader.
// The slave modport is the loader side; the master modport is the stream source / memory side.
interface spi_txmem_loader_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, mem_we, mem_addr, mem_din
  );

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/spi_txmem_loader.sv
// Packs a SysClk byte stream into 32-bit words for SPI transmit memory port A, locked out
// while SPI slave select is active. Define SPI_TXLOAD_FILL_EN for the power-up pattern fill.
module spi_txmem_loader #(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [31:0] FILL_PATTERN = 32'h5A6C_C6A5
) (
  input  logic              SysClk,
  input  logic              Reset,
  input  logic              spi_ss,
  spi_txmem_loader_if.slave bus,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   frame_words,
  output logic              overflow
);

  typedef enum logic [1:0] {
`ifdef SPI_TXLOAD_FILL_EN
    StFill,
`endif
    StAccept,
    StWrite
  } state_e;

`ifdef SPI_TXLOAD_FILL_EN
  localparam state_e StInit = StFill;
`else
  localparam state_e StInit = StAccept;
`endif
  localparam logic [ADDR_W:0] WOne = 1;

  state_e            state_q, state_d;
  logic              ss_meta_q, ss_idle_q;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              frame_open_q, frame_open_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic              done_pend_q, done_pend_d;
  logic [ADDR_W:0]   fw_pend_q, fw_pend_d;
  logic              frame_done_q;
  logic [ADDR_W:0]   frame_words_q;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              accept, full;

  // wptr MSB set means all 2^ADDR_W words of this frame are written; later bytes are dropped.
  assign full   = wptr_q[ADDR_W];
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge SysClk) begin
    if (Reset) state_q <= StInit;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef SPI_TXLOAD_FILL_EN
      StFill:   if (wptr_q[ADDR_W-1:0] == '1) state_d = StAccept;
`endif
      StAccept: if (accept && (full ? bus.in_last : (byte_cnt_q == 2'd3 || bus.in_last)))
                  state_d = StWrite;
      StWrite:  if (ss_idle_q) state_d = StAccept;
      default:  state_d = StAccept;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == StAccept) && ss_idle_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    last_d       = last_q;
    frame_open_d = frame_open_q;
    wptr_d       = wptr_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    done_pend_d  = 1'b0;
    fw_pend_d    = fw_pend_q;
    overflow_d   = overflow_q;
    unique case (state_q)
`ifdef SPI_TXLOAD_FILL_EN
      StFill: begin
        mem_we_d   = 1'b1;
        mem_addr_d = wptr_q[ADDR_W-1:0];
        mem_din_d  = FILL_PATTERN;
        wptr_d     = (wptr_q[ADDR_W-1:0] == '1) ? '0 : wptr_q + WOne;
      end
`endif
      StAccept: begin
        if (accept) begin
          if (!frame_open_q) overflow_d = 1'b0;
          frame_open_d = 1'b1;
          if (full) begin
            overflow_d = 1'b1;
            if (bus.in_last) last_d = 1'b1;
          end else begin
            // Lane 0 clears the word so a short final word carries zeros in unused lanes.
            if (byte_cnt_q == 2'd0) word_d = {24'h0, bus.in_data};
            else                    word_d[8*byte_cnt_q +: 8] = bus.in_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            last_d     = bus.in_last;
          end
        end
      end
      StWrite: begin
        if (ss_idle_q) begin
          if (!full) begin
            mem_we_d   = 1'b1;
            mem_addr_d = wptr_q[ADDR_W-1:0];
            mem_din_d  = word_q;
            wptr_d     = wptr_q + WOne;
          end
          if (last_q) begin
            done_pend_d  = 1'b1;
            fw_pend_d    = full ? wptr_q : wptr_q + WOne;
            wptr_d       = '0;
            byte_cnt_d   = '0;
            frame_open_d = 1'b0;
            last_d       = 1'b0;
          end
        end
      end
      default: ;
    endcase
    busy_d = frame_open_d || (state_d != StAccept);
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      ss_meta_q     <= 1'b0;
      ss_idle_q     <= 1'b0;
      byte_cnt_q    <= '0;
      word_q        <= '0;
      last_q        <= 1'b0;
      frame_open_q  <= 1'b0;
      wptr_q        <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      done_pend_q   <= 1'b0;
      fw_pend_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_words_q <= '0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      ss_meta_q     <= spi_ss;
      ss_idle_q     <= ss_meta_q;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      last_q        <= last_d;
      frame_open_q  <= frame_open_d;
      wptr_q        <= wptr_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      done_pend_q   <= done_pend_d;
      fw_pend_q     <= fw_pend_d;
      frame_done_q  <= done_pend_q;
      if (done_pend_q) frame_words_q <= fw_pend_q;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign frame_words  = frame_words_q;
  assign overflow     = overflow_q;

endmodule
